// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV32I/RV64I immediate generator with two-entry skid buffer
module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter bit ENABLE_UJ = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_unknown
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    typedef struct packed {
        logic            unknown;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
    } entry_t;

    entry_t dec;
    entry_t main_q;
    entry_t skid_q;
    logic   main_valid;
    logic   skid_valid;
    logic   accept;
    logic   fire;

    // Every format starts from a full-width copy of instr[31]; only the low
    // bits that carry payload are overwritten, which gives sign extension for free.
    always_comb begin
        dec         = '0;
        dec.imm     = {XLEN{in_instr[31]}};
        dec.fmt     = FMT_NONE;
        dec.unknown = 1'b0;
        unique case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec.fmt       = FMT_I;
                dec.imm[11:0] = in_instr[31:20];
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec.fmt       = FMT_I;
                    dec.imm[11:0] = in_instr[31:20];
                end else begin
                    dec.unknown = 1'b1;
                end
            end
            7'b0100011: begin
                dec.fmt       = FMT_S;
                dec.imm[11:0] = {in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec.fmt       = FMT_B;
                dec.imm[12:0] = {in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                if (ENABLE_UJ) begin
                    dec.fmt       = FMT_U;
                    dec.imm[31:0] = {in_instr[31:12], 12'b0};
                end else begin
                    dec.unknown = 1'b1;
                end
            end
            7'b1101111: begin
                if (ENABLE_UJ) begin
                    dec.fmt       = FMT_J;
                    dec.imm[20:0] = {in_instr[31], in_instr[19:12], in_instr[20],
                                     in_instr[30:21], 1'b0};
                end else begin
                    dec.unknown = 1'b1;
                end
            end
            default: dec.unknown = 1'b1;
        endcase
        if (dec.unknown) begin
            dec.imm = '0;
        end
        dec.target = in_pc + dec.imm;
    end

    assign accept = in_valid && in_ready;
    assign fire   = main_valid && out_ready;

    // Main only reloads when empty or draining, so a stalled output never changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || fire) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= accept;
                if (accept) begin
                    skid_q <= dec;
                end
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_q <= dec;
                end
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign in_ready    = !skid_valid;
    assign out_valid   = main_valid;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_target  = main_q.target;
    assign out_unknown = main_q.unknown;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed-vector bench for imm_gen_pipe
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [31:0] out_target;
    logic        out_unknown;

    logic        aux_flush = 1'b0;
    logic        aux_ready = 1'b1;
    logic        aux_valid = 1'b0;
    logic [31:0] aux_instr = '0;
    logic [31:0] aux_pc32 = '0;
    logic [63:0] aux_pc64 = '0;

    logic        nu_in_ready, nu_valid, nu_unknown;
    logic [31:0] nu_imm, nu_target;
    logic [2:0]  nu_fmt;
    logic        w_in_ready, w_valid, w_unknown;
    logic [63:0] w_imm, w_target;
    logic [2:0]  w_fmt;

    int n_vec = 0;
    int n_err = 0;

    imm_gen_pipe #(.XLEN(32), .ENABLE_UJ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_target(out_target), .out_unknown(out_unknown)
    );

    imm_gen_pipe #(.XLEN(32), .ENABLE_UJ(1'b0)) dut_nouj (
        .clk(clk), .rst_n(rst_n), .flush(aux_flush),
        .in_valid(aux_valid), .in_ready(nu_in_ready), .in_instr(aux_instr), .in_pc(aux_pc32),
        .out_valid(nu_valid), .out_ready(aux_ready), .out_imm(nu_imm),
        .out_fmt(nu_fmt), .out_target(nu_target), .out_unknown(nu_unknown)
    );

    imm_gen_pipe #(.XLEN(64), .ENABLE_UJ(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(aux_flush),
        .in_valid(aux_valid), .in_ready(w_in_ready), .in_instr(aux_instr), .in_pc(aux_pc64),
        .out_valid(w_valid), .out_ready(aux_ready), .out_imm(w_imm),
        .out_fmt(w_fmt), .out_target(w_target), .out_unknown(w_unknown)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one word and checks it on the outputs right after the accepting edge.
    task automatic apply(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] e_imm, input logic [2:0] e_fmt,
                         input logic e_unk, input logic [31:0] e_tgt);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".ready"}, in_ready, 1);
        check({tag, ".imm"}, out_imm, e_imm);
        check({tag, ".fmt"}, out_fmt, e_fmt);
        check({tag, ".unk"}, out_unknown, e_unk);
        check({tag, ".tgt"}, out_target, e_tgt);
    endtask

    task automatic apply_aux(input logic [31:0] instr);
        @(negedge clk);
        aux_valid = 1'b1;
        aux_instr = instr;
        aux_pc32  = 32'h100;
        aux_pc64  = 64'h100;
        tick();
    endtask

    initial begin
        #12;
        check("rst.out_valid", out_valid, 0);
        check("rst.in_ready", in_ready, 1);
        check("rst.imm", out_imm, 0);
        check("rst.fmt", out_fmt, 0);
        check("rst.tgt", out_target, 0);
        check("rst.unk", out_unknown, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back decode at full rate
        apply("addi", 32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'd1, 1'b0, 32'h000000FF);
        apply("sw",   32'hFE112E23, 32'h100, 32'hFFFFFFFC, 3'd2, 1'b0, 32'h000000FC);
        apply("beq",  32'hFE000CE3, 32'h100, 32'hFFFFFFF8, 3'd3, 1'b0, 32'h000000F8);
        apply("lui",  32'h123450B7, 32'h100, 32'h12345000, 3'd4, 1'b0, 32'h12345100);
        apply("jal",  32'h008000EF, 32'h100, 32'h00000008, 3'd5, 1'b0, 32'h00000108);
        apply("add",  32'h00000033, 32'h100, 32'h00000000, 3'd0, 1'b1, 32'h00000100);
        apply("lw",   32'h80002003, 32'h100, 32'hFFFFF800, 3'd1, 1'b0, 32'hFFFFF900);
        apply("wrap", 32'h00100093, 32'hFFFFFFFF, 32'h00000001, 3'd1, 1'b0, 32'h00000000);
        @(negedge clk);
        in_valid = 1'b0;
        tick();
        check("drain.valid", out_valid, 0);

        apply_aux(32'h008000EF);
        check("nouj.jal.fmt", nu_fmt, 0);
        check("nouj.jal.unk", nu_unknown, 1);
        check("nouj.jal.imm", nu_imm, 0);
        check("nouj.jal.tgt", nu_target, 32'h100);
        check("x64.jal.imm", w_imm, 64'h8);
        apply_aux(32'h800000B7);
        check("x64.lui.imm", w_imm, 64'hFFFFFFFF80000000);
        check("x64.lui.fmt", w_fmt, 4);
        check("x64.lui.tgt", w_target, 64'hFFFFFFFF80000100);
        check("nouj.lui.unk", nu_unknown, 1);
        apply_aux(32'hFFF0009B);
        check("x64.addiw.imm", w_imm, 64'hFFFFFFFFFFFFFFFF);
        check("x64.addiw.fmt", w_fmt, 1);
        check("x64.addiw.unk", w_unknown, 0);
        check("x32.addiw.unk", nu_unknown, 1);
        check("x32.addiw.fmt", nu_fmt, 0);
        @(negedge clk);
        aux_valid = 1'b0;

        // back-pressure: A, B absorbed, C stalls
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        in_pc     = 32'h0;
        @(negedge clk);
        check("bp.a.valid", out_valid, 1);
        check("bp.a.ready", in_ready, 1);
        in_instr = 32'h00200093;
        @(negedge clk);
        check("bp.b.ready", in_ready, 0);
        check("bp.b.head", out_imm, 1);
        in_instr = 32'h00300093;
        @(negedge clk);
        check("bp.hold.imm", out_imm, 1);
        check("bp.hold.ready", in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.out_b.imm", out_imm, 2);
        check("bp.out_b.ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.out_c.imm", out_imm, 3);
        check("bp.out_c.valid", out_valid, 1);
        @(negedge clk);
        check("bp.empty", out_valid, 0);

        // flush with both entries full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00400093;
        @(negedge clk);
        in_instr = 32'h00500093;
        @(negedge clk);
        check("fl.full", in_ready, 0);
        flush    = 1'b1;
        in_instr = 32'h00600093;
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        check("fl.valid", out_valid, 0);
        check("fl.ready", in_ready, 1);
        out_ready = 1'b1;
        @(negedge clk);
        check("fl.nodrop1", out_valid, 0);
        @(negedge clk);
        check("fl.nodrop2", out_valid, 0);

        // async reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_pc     = 32'h100;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.valid", out_valid, 0);
        check("ar.imm", out_imm, 0);
        check("ar.tgt", out_target, 0);
        check("ar.fmt", out_fmt, 0);
        check("ar.ready", in_ready, 1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00700093;
        tick();
        check("ar.first.valid", out_valid, 1);
        check("ar.first.imm", out_imm, 7);
        @(negedge clk);
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined immediate generator for the decode stage. It accepts one instruction and its PC per cycle over a valid/ready handshake. For each instruction it produces the sign-extended immediate for all RV32I/RV64I formats (I, S, B, U, J), a format code, and the PC-relative target `pc + imm`. Output is registered behind a two-entry skid buffer, so full throughput holds under back-pressure, and a flush input squashes in-flight entries on redirect.

## Interface
Parameters:
- `XLEN`, default 32: datapath width, 32 or 64; `out_imm`, `out_target` and `in_pc` are XLEN wide.
- `ENABLE_UJ`, default 1: when 0, U/J opcodes decode as unknown.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous squash of both buffer entries.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: block can accept; registered, equal to `!skid_valid`.
- `in_instr` in 32: instruction word.
- `in_pc` in XLEN: PC of `in_instr`.
- `out_valid` out 1: output entry valid.
- `out_ready` in 1: consumer accepts output.
- `out_imm` out XLEN: sign-extended immediate.
- `out_fmt` out 3: format code; 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- `out_target` out XLEN: `pc + imm`, modulo 2^XLEN.
- `out_unknown` out 1: opcode not recognised.

## Operation
Decode on `in_instr[6:0]`, combinational before the buffer:
- **I-type:** opcodes 0010011, 0000011, 1100111, plus 0011011 when XLEN=64.
  - imm = sext(instr[31:20]).
- **S-type:** opcode 0100011.
  - imm = sext({instr[31:25], instr[11:7]}).
- **B-type:** opcode 1100011.
  - imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- **U-type:** opcodes 0110111, 0010111.
  - imm = sext({instr[31:12], 12'b0}).
  - At XLEN=64, bit 31 is replicated into [63:32].
- **J-type:** opcode 1101111.
  - imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- **Everything else, and U/J when ENABLE_UJ=0:**
  - imm = 0, fmt = NONE, unknown = 1.
- Sign extension always replicates instr[31] up to bit XLEN-1.
- `out_target = in_pc + imm` in XLEN-bit arithmetic; carry out is discarded. It is computed for every format, including NONE.

Buffer:
- The buffer has two entries: main (drives the outputs) and skid.
- Accept fires when `in_valid && in_ready`.
- Output fire fires when `out_valid && out_ready`.
- Per-cycle update, in priority order:
  1. `flush`: main_valid and skid_valid clear. Any word accepted in the same cycle is dropped.
  2. Main empty, or output fire, with skid full: skid moves to main. An accepted word goes to skid.
  3. Main empty, or output fire, with skid empty: an accepted word goes to main. Otherwise main_valid clears if it fired.
  4. Main full, no output fire, accept: the word goes to skid.
- `in_ready` deasserts only when skid is full.
- Holding rule: while `out_valid && !out_ready`, every output holds its value.
- Order is strictly preserved; no entry is dropped or duplicated except on flush.

## Timing
- **Reset (async assert, sync deassert by the system):**
  - `out_valid` = 0, `in_ready` = 1.
  - `out_imm`, `out_target`, `out_fmt`, `out_unknown` = 0.
  - skid_valid = 0.
- **Latency:** a word accepted at edge N appears on the outputs after edge N, when the buffer was empty.
- **Throughput:** one word per cycle while `out_ready`=1.
- **Back-pressure:** with `out_ready` held at 0, the block absorbs two words. `in_ready` falls the cycle after the second accept.
- **Skid drain:** one cycle after `out_ready` rises, `in_ready` returns to 1.
- **Flush:** takes effect at the next edge.
  - After it, `out_valid` = 0 and `in_ready` = 1.
  - Output data registers need not clear.
- **Reset mid-stream:** both entries are lost immediately; no output fire occurs.
- **Simultaneous accept and fire** with skid empty keeps full rate with no bubble.

## Test plan
- **Decode, XLEN=32, PC=0x100, `out_ready`=1:**
  - 0xFFF00093 (addi) → imm 0xFFFFFFFF, fmt 1, target 0xFF.
  - 0xFE112E23 (sw) → imm 0xFFFFFFFC, fmt 2.
  - 0xFE000CE3 (beq) → imm 0xFFFFFFF8, fmt 3, target 0xF8.
  - 0x123450B7 (lui) → imm 0x12345000, fmt 4.
  - 0x008000EF (jal) → imm 8, fmt 5, target 0x108.
  - 0x00000033 → imm 0, fmt 0, unknown 1.
- **ENABLE_UJ=0:** 0x008000EF → fmt 0, unknown 1, imm 0.
- **XLEN=64:**
  - 0x800000B7 → imm 0xFFFFFFFF80000000.
  - 0xFFF0009B (addiw) → imm all-ones, fmt 1.
- **Back-pressure:** stream words A, B, C with `out_ready`=0.
  - A and B are accepted; `in_ready`=0 the cycle after B; C stalls.
  - `out_ready`=1 then yields A, B, C in order; no loss, no duplicate.
- **Flush:** with both entries full, assert `flush` together with `in_valid`.
  - Next cycle `out_valid`=0 and `in_ready`=1.
  - The word offered in the flush cycle is never output.
- **Reset:** assert `rst_n`=0 mid-stream asynchronously.
  - Outputs go to 0 without waiting for a clock edge.
  - After release, the first word accepted appears one cycle later.
